// File: rtl/srcx1_grp_pack.sv
// Packs GRP_N consecutive IQ samples into one wide word behind a first-word-fall-through
// FIFO, checking frame-head period and group alignment along the way.
module srcx1_grp_pack #(
    parameter int unsigned GRP_N      = 4,
    parameter int unsigned FRM_LEN    = 4915200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  asy_rst,
    input  logic                  i_en,
    input  logic                  i_fram_hd,
    input  logic                  i_ant8_sel,
    input  logic [31:0]           i_data_iq,
    input  logic                  i_grp_rdy,
    output logic                  o_grp_vld,
    output logic [32*GRP_N-1:0]   o_grp_data,
    output logic                  o_grp_first,
    input  logic                  i_err_clr,
    output logic                  o_err_align,
    output logic                  o_err_frm,
    output logic                  o_err_ovf,
    output logic [15:0]           o_frm_cnt,
    output logic [31:0]           o_grp_cnt
);
    localparam int unsigned DW = 32;
    localparam int unsigned WW = DW * GRP_N;
    localparam int unsigned LW = (GRP_N > 1) ? $clog2(GRP_N) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(FRM_LEN + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ALIGN   = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [LW-1:0] lane_q,      lane_d;
    logic [WW-1:0] word_q,      word_d;
    logic          first_q,     first_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          armed_q,     armed_d;
    logic          err_align_q, err_align_d;
    logic          err_frm_q,   err_frm_d;
    logic          err_ovf_q,   err_ovf_d;
    logic [15:0]   frm_cnt_q,   frm_cnt_d;
    logic [31:0]   grp_cnt_q,   grp_cnt_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          vld_q,       vld_d;
    logic [WW:0]   mem_q [FIFO_DEPTH];

    logic          push_c, done_c, pop_c, full_c, wr_en_c;
    logic          set_align_c, set_frm_c, set_ovf_c;
    logic [WW:0]   push_word_c;

    // Group assembly FSM, frame timer, FIFO bookkeeping and sticky errors
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        word_d      = word_q;
        first_d     = first_q;
        timer_d     = timer_q;
        armed_d     = armed_q;
        push_c      = 1'b0;
        done_c      = 1'b0;
        set_align_c = 1'b0;
        set_frm_c   = 1'b0;
        push_word_c = {first_q, word_q};
        push_word_c[(GRP_N-1)*DW +: DW] = i_data_iq;

        if (!i_en) begin
            state_d = ST_IDLE;
            lane_d  = '0;
            timer_d = '0;
            armed_d = 1'b0;
        end else begin
            if (i_fram_hd) begin
                timer_d   = '0;
                armed_d   = 1'b1;
                set_frm_c = armed_q && (timer_q != TW'(FRM_LEN - 1));
            end else if (timer_q != TW'(FRM_LEN)) begin
                timer_d = timer_q + TW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_fram_hd) begin
                        state_d = ST_ALIGN;
                        first_d = 1'b1;
                    end
                end
                ST_ALIGN, ST_COLLECT: begin
                    done_c = (state_q == ST_COLLECT) && (lane_q == LW'(GRP_N - 1))
                             && (!i_ant8_sel || i_fram_hd);
                    if (done_c) begin
                        push_c  = 1'b1;
                        first_d = 1'b0;
                        state_d = ST_ALIGN;
                        lane_d  = '0;
                    end
                    if (i_fram_hd) begin
                        first_d = 1'b1;
                        state_d = ST_ALIGN;
                        lane_d  = '0;
                    end
                    if (i_ant8_sel) begin
                        // a head in the same cycle legitimately realigns the group
                        set_align_c = (state_q == ST_COLLECT) && !i_fram_hd;
                        word_d[DW-1:0] = i_data_iq;
                        lane_d  = LW'(1);
                        state_d = ST_COLLECT;
                    end else if (!done_c && !i_fram_hd && state_q == ST_COLLECT) begin
                        for (int k = 0; k < int'(GRP_N); k++) begin
                            if (lane_q == LW'(k)) word_d[k*DW +: DW] = i_data_iq;
                        end
                        lane_d = lane_q + LW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        pop_c     = vld_q && i_grp_rdy;
        full_c    = (cnt_q == CW'(FIFO_DEPTH));
        wr_en_c   = push_c && (!full_c || pop_c);
        set_ovf_c = push_c && full_c && !pop_c;
        wr_ptr_d  = wr_ptr_q + PW'(wr_en_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_c);
        cnt_d     = cnt_q + CW'(wr_en_c) - CW'(pop_c);
        vld_d     = (cnt_d != '0);

        frm_cnt_d   = frm_cnt_q + 16'(i_en && i_fram_hd);
        grp_cnt_d   = grp_cnt_q + 32'(wr_en_c);
        err_align_d = (err_align_q && !i_err_clr) || set_align_c;
        err_frm_d   = (err_frm_q   && !i_err_clr) || set_frm_c;
        err_ovf_d   = (err_ovf_q   && !i_err_clr) || set_ovf_c;
    end

    always_ff @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            word_q      <= '0;
            first_q     <= 1'b0;
            timer_q     <= '0;
            armed_q     <= 1'b0;
            err_align_q <= 1'b0;
            err_frm_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            frm_cnt_q   <= '0;
            grp_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            first_q     <= first_d;
            timer_q     <= timer_d;
            armed_q     <= armed_d;
            err_align_q <= err_align_d;
            err_frm_q   <= err_frm_d;
            err_ovf_q   <= err_ovf_d;
            frm_cnt_q   <= frm_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
        end
    end

    // Storage is reset so the head entry reads as zero out of reset
    always_ff @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else if (wr_en_c) begin
            mem_q[wr_ptr_q] <= push_word_c;
        end
    end

    assign o_grp_vld   = vld_q;
    assign o_grp_data  = mem_q[rd_ptr_q][WW-1:0];
    assign o_grp_first = mem_q[rd_ptr_q][WW];
    assign o_err_align = err_align_q;
    assign o_err_frm   = err_frm_q;
    assign o_err_ovf   = err_ovf_q;
    assign o_frm_cnt   = frm_cnt_q;
    assign o_grp_cnt   = grp_cnt_q;

endmodule

// File: tb/tb_srcx1_grp_pack.sv
// Bench for srcx1_grp_pack: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a queue-based model of groups, frames and the output FIFO.
module tb_srcx1_grp_pack;
    localparam int unsigned GRP_N   = 4;
    localparam int unsigned FRM_LEN = 16;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned WW      = 32 * GRP_N;
    localparam int unsigned CKW     = WW + 1;

    logic            clk = 1'b0;
    logic            asy_rst = 1'b0;
    logic            i_en = 1'b0, i_fram_hd = 1'b0, i_ant8_sel = 1'b0;
    logic [31:0]     i_data_iq = '0;
    logic            i_grp_rdy = 1'b0, i_err_clr = 1'b0;
    logic            o_grp_vld, o_grp_first, o_err_align, o_err_frm, o_err_ovf;
    logic [WW-1:0]   o_grp_data;
    logic [15:0]     o_frm_cnt;
    logic [31:0]     o_grp_cnt;

    always #5 clk = ~clk;

    srcx1_grp_pack #(.GRP_N(GRP_N), .FRM_LEN(FRM_LEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .asy_rst(asy_rst), .i_en(i_en), .i_fram_hd(i_fram_hd),
        .i_ant8_sel(i_ant8_sel), .i_data_iq(i_data_iq), .i_grp_rdy(i_grp_rdy),
        .o_grp_vld(o_grp_vld), .o_grp_data(o_grp_data), .o_grp_first(o_grp_first),
        .i_err_clr(i_err_clr), .o_err_align(o_err_align), .o_err_frm(o_err_frm),
        .o_err_ovf(o_err_ovf), .o_frm_cnt(o_frm_cnt), .o_grp_cnt(o_grp_cnt)
    );

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    // Reference model: frame activity, the partial group as a list, the FIFO as a queue
    bit            m_active, m_first, m_armed;
    bit            m_err_align, m_err_frm, m_err_ovf;
    bit [15:0]     m_frm_cnt;
    bit [31:0]     m_grp_cnt;
    int unsigned   m_last_hd;
    logic [31:0]   m_grp[$];
    logic [CKW-1:0] m_fifo[$];

    task automatic check(input string tag, input logic [CKW-1:0] got, input logic [CKW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_first = 0; m_armed = 0;
        m_err_align = 0; m_err_frm = 0; m_err_ovf = 0;
        m_frm_cnt = '0; m_grp_cnt = '0; m_last_hd = 0;
        m_grp.delete(); m_fifo.delete();
    endtask

    function automatic bit head_seen();
        bit e;
        e = m_armed && ((cyc - m_last_hd) != FRM_LEN);
        m_frm_cnt++;
        m_first   = 1;
        m_armed   = 1;
        m_last_hd = cyc;
        return e;
    endfunction

    task automatic model_step();
        bit pop, push, done, s_al, s_fr, s_ov;
        logic [CKW-1:0] pw;
        if (!asy_rst) begin
            model_reset();
            return;
        end
        pop = (m_fifo.size() != 0) && i_grp_rdy;
        push = 0; done = 0; s_al = 0; s_fr = 0; s_ov = 0; pw = '0;
        if (!i_en) begin
            m_active = 0; m_armed = 0; m_grp.delete();
        end else if (!m_active) begin
            if (i_fram_hd) begin
                m_active = 1;
                s_fr = head_seen();
            end
        end else begin
            if (m_grp.size() == GRP_N - 1 && (!i_ant8_sel || i_fram_hd)) begin
                pw[WW] = m_first;
                for (int k = 0; k < int'(GRP_N) - 1; k++) pw[k*32 +: 32] = m_grp[k];
                pw[(GRP_N-1)*32 +: 32] = i_data_iq;
                push = 1; done = 1; m_first = 0;
                m_grp.delete();
            end
            if (i_fram_hd) begin
                s_fr = head_seen();
                m_grp.delete();
            end
            if (i_ant8_sel) begin
                if (m_grp.size() != 0 && !i_fram_hd) s_al = 1;
                m_grp.delete();
                m_grp.push_back(i_data_iq);
            end else if (!done && !i_fram_hd && m_grp.size() != 0) begin
                m_grp.push_back(i_data_iq);
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() == DEPTH) s_ov = 1;
            else begin
                m_fifo.push_back(pw);
                m_grp_cnt++;
            end
        end
        m_err_align = (m_err_align && !i_err_clr) || s_al;
        m_err_frm   = (m_err_frm   && !i_err_clr) || s_fr;
        m_err_ovf   = (m_err_ovf   && !i_err_clr) || s_ov;
    endtask

    task automatic check_outputs();
        check("vld", CKW'(o_grp_vld), CKW'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check("data", {o_grp_first, o_grp_data}, m_fifo[0]);
        check("err_align", CKW'(o_err_align), CKW'(m_err_align));
        check("err_frm",   CKW'(o_err_frm),   CKW'(m_err_frm));
        check("err_ovf",   CKW'(o_err_ovf),   CKW'(m_err_ovf));
        check("frm_cnt",   CKW'(o_frm_cnt),   CKW'(m_frm_cnt));
        check("grp_cnt",   CKW'(o_grp_cnt),   CKW'(m_grp_cnt));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vld"},   CKW'(o_grp_vld), '0);
        check({tag, "_data"},  CKW'(o_grp_data), '0);
        check({tag, "_first"}, CKW'(o_grp_first), '0);
        check({tag, "_errs"},  CKW'({o_err_align, o_err_frm, o_err_ovf}), '0);
        check({tag, "_cnts"},  CKW'({o_frm_cnt, o_grp_cnt}), '0);
    endtask

    task automatic cyc_step(input bit en, input bit hd, input bit sel, input bit rdy,
                            input bit clr, input logic [31:0] data);
        i_en = en; i_fram_hd = hd; i_ant8_sel = sel; i_grp_rdy = rdy;
        i_err_clr = clr; i_data_iq = data;
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check_outputs();
    endtask

    initial begin
        int unsigned t, flen, rdy_pct, dis_left;
        bit en, hd, sel, rdy, clr;
        bit [15:0] base_f;
        bit [31:0] base_g;
        model_reset();

        // reset state
        for (int n = 0; n < 3; n++) cyc_step(1, 1, 1, 1, 0, 32'hdead_beef);
        check_zero("reset");
        asy_rst = 1'b1;

        // aligned stream: four words per frame, data = cycle index
        for (int n = 0; n < 64; n++) begin
            cyc_step(1, (n % 16) == 0, (n % 4) == 1, 1, 0, 32'(n));
            if (n == 3) check("lat_before", CKW'(o_grp_vld), '0);
            if (n == 4) check("first_word", {o_grp_first, o_grp_data},
                              {1'b1, 32'd4, 32'd3, 32'd2, 32'd1});
        end
        check("frm_cnt4", CKW'(o_frm_cnt), CKW'(4));

        // extra marker at lane index 2
        cyc_step(0, 0, 0, 1, 0, '0);
        for (int n = 0; n < 24; n++) begin
            cyc_step(1, n == 0, (n == 1) || (n >= 3 && (n % 4) == 3), 1, 0, 32'(n));
            if (n == 3) check("align_set", CKW'(o_err_align), CKW'(1));
            if (n == 6) check("realign_word", {o_grp_first, o_grp_data},
                              {1'b1, 32'd6, 32'd5, 32'd4, 32'd3});
        end
        cyc_step(0, 0, 0, 1, 1, '0);
        check("align_clr", CKW'(o_err_align), '0);

        // frame spacing 16 then 15
        cyc_step(0, 0, 0, 1, 0, '0);
        base_f = m_frm_cnt;
        for (int n = 0; n < 32; n++) begin
            cyc_step(1, (n == 0) || (n == 16) || (n == 31), 0, 1, 0, 32'(n));
            if (n == 16) check("frm_ok16", CKW'(o_err_frm), '0);
        end
        check("frm_err15", CKW'(o_err_frm), CKW'(1));
        check("frm_cnt3", CKW'(o_frm_cnt), CKW'(base_f + 16'd3));

        // overflow with a stalled sink, then push and pop while full
        cyc_step(0, 0, 0, 1, 1, '0);
        base_g = m_grp_cnt;
        for (int n = 0; n <= 40; n++) begin
            cyc_step(1, n == 0, (n % 4) == 1, n == 40, n == 38, 32'(n + 100));
            if (n == 20 || n == 37) check("stall_head", {o_grp_first, o_grp_data},
                                          {1'b1, 32'd104, 32'd103, 32'd102, 32'd101});
            if (n == 37) begin
                check("ovf_set", CKW'(o_err_ovf), CKW'(1));
                check("grp_cnt8", CKW'(o_grp_cnt), CKW'(base_g + 32'd8));
            end
        end
        check("full_pushpop_ovf", CKW'(o_err_ovf), '0);
        check("grp_cnt9", CKW'(o_grp_cnt), CKW'(base_g + 32'd9));
        check("full_pushpop_head", {o_grp_first, o_grp_data},
              {1'b0, 32'd108, 32'd107, 32'd106, 32'd105});
        for (int n = 0; n < 10; n++) cyc_step(1, 0, 0, 1, 0, 32'(n));
        check("drained", CKW'(o_grp_vld), '0);

        // randomized traffic
        t = 0; flen = FRM_LEN; rdy_pct = 100; dis_left = 0;
        for (int n = 0; n < 1500; n++) begin
            if ((n % 100) == 0) rdy_pct = $urandom_range(0, 100);
            if (dis_left > 0) begin
                en = 0; dis_left--;
            end else begin
                en = 1;
                if ($urandom_range(0, 299) == 0) dis_left = 3;
            end
            hd  = (t == 0);
            sel = ((t % 4) == 1) ^ ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 99) < rdy_pct);
            clr = ($urandom_range(0, 49) == 0);
            cyc_step(en, hd, sel, rdy, clr, $urandom);
            t++;
            if (t == flen) begin
                t = 0;
                flen = ($urandom_range(0, 7) == 0) ? FRM_LEN - 1 + $urandom_range(0, 2) : FRM_LEN;
            end
        end

        // async reset mid-group with the FIFO holding a word
        for (int n = 0; n < 12; n++) cyc_step(0, 0, 0, 1, 0, '0);
        for (int n = 0; n < 7; n++) cyc_step(1, n == 0, (n % 4) == 1, 0, 0, 32'(n + 500));
        check("pre_rst_vld", CKW'(o_grp_vld), CKW'(1));
        #2 asy_rst = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        #2 asy_rst = 1'b1;
        for (int n = 0; n < 12; n++) cyc_step(1, 0, (n % 4) == 1, 1, 0, 32'(n + 600));
        check("no_word_wo_head", CKW'(o_grp_vld), '0);
        for (int n = 0; n < 9; n++) cyc_step(1, n == 0, (n % 4) == 1, 1, 0, 32'(n + 700));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/srcx1_grp_pack.md
Name: srcx1_grp_pack

Overview:
Downstream consumer of the srcx1 source-interface stage. Takes the 32-bit IQ stream with its frame head and 4-antenna group marker (ant8_sel), and packs each group of GRP_N consecutive samples into one wide word. Words are buffered in a small FIFO and presented on a valid/ready handshake to the next datapath stage. The block also checks frame period and group alignment, and exposes sticky error flags and counters for register readback.

Parameters:
GRP_N, 4, samples per group; fixed at 4 in this revision, output word is 32*GRP_N bits.
FRM_LEN, 4915200, expected clocks between consecutive frame heads.
FIFO_DEPTH, 8, packed-word FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock
asy_rst  input  1  asynchronous reset, active-low
i_en  input  1  block enable, synchronous
i_fram_hd  input  1  frame head pulse from srcx1 stage
i_ant8_sel  input  1  group-start marker; the sample in this cycle is lane 0
i_data_iq  input  32  IQ sample, valid every cycle
i_grp_rdy  input  1  downstream ready
o_grp_vld  output  1  packed word valid
o_grp_data  output  128  packed group; lane k occupies bits [32k+31:32k]
o_grp_first  output  1  word is the first complete group after a frame head
i_err_clr  input  1  clears all sticky errors
o_err_align  output  1  sticky: group marker arrived mid-group
o_err_frm  output  1  sticky: frame head period is not FRM_LEN
o_err_ovf  output  1  sticky: group dropped because the FIFO was full
o_frm_cnt  output  16  accepted frame heads, wraps
o_grp_cnt  output  32  groups pushed into the FIFO, wraps

Behaviour:
- Reset (asy_rst=0): every output is 0; FSM=IDLE; FIFO empty; all counters 0; frame timer disarmed.
- FSM states: IDLE, ALIGN, COLLECT. A lane index (0..GRP_N-1) runs in COLLECT.
- IDLE: on i_fram_hd & i_en, go to ALIGN, increment o_frm_cnt, arm first-flag.
- ALIGN: on i_ant8_sel, store the sample into lane 0 (lane index becomes 1) and go to COLLECT.
- COLLECT: store each sample into the current lane, then increment the lane index.
  - On the sample stored in lane GRP_N-1, push {first-flag, word} to the FIFO, clear first-flag, return to ALIGN.
  - If i_ant8_sel and i_fram_hd both fire in the same cycle, the group at lane GRP_N-1 still completes and pushes.
- i_ant8_sel in COLLECT with lane index != 0:
  - Set o_err_align.
  - Discard the partial group.
  - Restart with the current sample as lane 0.
- i_fram_hd in ALIGN or COLLECT:
  - Discard the partial group, unless it completes this cycle.
  - Increment o_frm_cnt, arm first-flag, go to ALIGN.
  - If the same cycle also has i_ant8_sel, the current sample becomes lane 0 (state COLLECT).
- i_en=0: go to IDLE synchronously and drop the partial group. The FIFO keeps draining. Counters hold. The frame timer disarms.
- Frame timer:
  - Cleared to 0 on an accepted frame head; increments otherwise; saturates at FRM_LEN.
  - At the second and later frame heads, timer != FRM_LEN-1 sets o_err_frm.
  - The first frame head after reset or after enable is not checked.
- FIFO:
  - First-word fall-through: o_grp_vld = !empty, and o_grp_data/o_grp_first show the head entry.
  - Pop when o_grp_vld & i_grp_rdy.
  - Latency: group completes at cycle T with the FIFO empty, so o_grp_vld=1 at T+1.
  - Push while full with no pop: drop the group, set o_err_ovf, and do not increment o_grp_cnt.
  - Push and pop in the same cycle while full: the push is accepted, occupancy is unchanged, and o_grp_cnt increments.
  - Output data is stable while o_grp_vld=1 and i_grp_rdy=0.
- Sticky errors clear on i_err_clr. If a set and a clear occur in the same cycle, set wins.
- o_frm_cnt and o_grp_cnt wrap modulo their widths.

Test Plan:
- Aligned stream, FRM_LEN=16, i_grp_rdy=1, i_data_iq=cycle index, marker every 4 cycles from cycle 1 after the head -> four words per frame, e.g. {4,3,2,1}, o_grp_first on the first word only, no errors, o_grp_vld one cycle after lane 3.
- Marker at lane index 2 (extra pulse) -> o_err_align=1, partial group dropped, next word starts at the marker sample; i_err_clr -> flag 0.
- Frame heads at spacing 16, then 15, FRM_LEN=16 -> o_err_frm set only at the 15-spaced head; o_frm_cnt=3.
- i_grp_rdy=0 with FIFO_DEPTH=8, push 9 groups -> 8 stored, o_err_ovf=1, o_grp_cnt=8; then rdy=1 -> 8 words drained in order, data held stable while stalled.
- FIFO full with push and pop in the same cycle -> no overflow, o_grp_cnt increments, occupancy stays at 8.
- asy_rst low mid-COLLECT with FIFO non-empty -> all outputs 0 immediately; after release, no word until a new frame head and marker arrive.
